// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - AXI4-Lite slave CSR register file with RO status and protection checks
module axi_lite_regfile #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    NUM_REGS   = 8,
   parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
   parameter bit                    PRIV_ONLY  = 1'b0,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   input  logic [ADDR_WIDTH-1:0]          awaddr,
   input  logic                           awvalid,
   output logic                           awready,
   input  logic [2:0]                     awprot,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic [DATA_WIDTH/8-1:0]        wstrb,
   input  logic                           wvalid,
   output logic                           wready,
   output logic [1:0]                     bresp,
   output logic                           bvalid,
   input  logic                           bready,
   input  logic [ADDR_WIDTH-1:0]          araddr,
   input  logic                           arvalid,
   output logic                           arready,
   input  logic [2:0]                     arprot,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic [1:0]                     rresp,
   output logic                           rvalid,
   input  logic                           rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            wr_pulse,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status
);

   localparam int         LANES  = DATA_WIDTH / 8;
   localparam int         LSB    = $clog2(LANES);
   localparam int         IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   // register storage; RO entries stay at zero so their reg_q slices read 0
   logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

   // write-side holding buffers
   logic                    aw_held;
   logic [ADDR_WIDTH-1:0]   aw_addr_q;
   logic [2:0]              aw_prot_q;
   logic                    w_held;
   logic [DATA_WIDTH-1:0]   w_data_q;
   logic [LANES-1:0]        w_strb_q;

   // decode of the held write address and of the live read address
   logic [ADDR_WIDTH-1:0]   aw_word;
   logic [ADDR_WIDTH-1:0]   ar_word;
   logic [IDX_W-1:0]        aw_idx;
   logic [IDX_W-1:0]        ar_idx;
   logic                    aw_in_range;
   logic                    ar_in_range;
   logic                    w_ok;
   logic                    r_ok;
   logic                    commit;
   logic [DATA_WIDTH-1:0]   merged;
   logic [DATA_WIDTH-1:0]   rd_val;

   assign awready = !aw_held && !bvalid;
   assign wready  = !w_held && !bvalid;
   assign arready = !rvalid;

   assign aw_word     = aw_addr_q >> LSB;
   assign ar_word     = araddr >> LSB;
   assign aw_idx      = aw_word[IDX_W-1:0];
   assign ar_idx      = ar_word[IDX_W-1:0];
   assign aw_in_range = aw_word < ADDR_WIDTH'(NUM_REGS);
   assign ar_in_range = ar_word < ADDR_WIDTH'(NUM_REGS);

   // a write fails on bad index, RO target or missing privilege; a read only on the latter two-but-one
   assign w_ok   = aw_in_range && !RO_MASK[aw_idx] && !(PRIV_ONLY && !aw_prot_q[0]);
   assign r_ok   = ar_in_range && !(PRIV_ONLY && !arprot[0]);
   assign commit = aw_held && w_held && !bvalid;

   // byte-lane merge of the held write data into the current register value
   always_comb begin
      merged = regs[aw_idx];
      for (int b = 0; b < LANES; b++) begin
         if (w_strb_q[b]) merged[b*8 +: 8] = w_data_q[b*8 +: 8];
      end
   end

   // read source selection: RO registers come straight from hardware status
   always_comb begin
      rd_val = '0;
      if (r_ok) begin
         if (RO_MASK[ar_idx]) rd_val = hw_status[ar_idx*DATA_WIDTH +: DATA_WIDTH];
         else                 rd_val = regs[ar_idx];
      end
   end

   // write path: AW/W capture, commit into the register array, B response
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         aw_held   <= 1'b0;
         aw_addr_q <= '0;
         aw_prot_q <= '0;
         w_held    <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid    <= 1'b0;
         bresp     <= OKAY;
         wr_pulse  <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= RO_MASK[i] ? '0 : RESET_VAL;
         end
      end else begin
         wr_pulse <= '0;
         if (awvalid && awready) begin
            aw_held   <= 1'b1;
            aw_addr_q <= awaddr;
            aw_prot_q <= awprot;
         end
         if (wvalid && wready) begin
            w_held   <= 1'b1;
            w_data_q <= wdata;
            w_strb_q <= wstrb;
         end
         if (bvalid && bready) bvalid <= 1'b0;
         if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= w_ok ? OKAY : SLVERR;
            if (w_ok) begin
               regs[aw_idx]     <= merged;
               wr_pulse[aw_idx] <= 1'b1;
            end
         end
      end
   end

   // read path: single outstanding read, response held until accepted
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         rvalid <= 1'b0;
         rdata  <= '0;
         rresp  <= OKAY;
      end else begin
         if (rvalid && rready) rvalid <= 1'b0;
         if (arvalid && arready) begin
            rvalid <= 1'b1;
            rdata  <= rd_val;
            rresp  <= r_ok ? OKAY : SLVERR;
         end
      end
   end

   genvar gi;
   for (gi = 0; gi < NUM_REGS; gi++) begin : g_regq
      assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = regs[gi];
   end

endmodule

// File: doc/axi_lite_regfile.md
Name: axi_lite_regfile

Overview:
Parametrised AXI4-Lite slave register file that terminates one AXI4-Lite link, using the same channel signal set, and exposes NUM_REGS control/status registers to hardware. Write address and write data are accepted independently, byte strobes are honoured, and protection-based access checks are applied. Read-only status registers are supported, and decode errors and protection violations return SLVERR. It sits behind a crossbar slave port as the standard peripheral CSR block.

Parameters:
ADDR_WIDTH, 32, AXI address width.
DATA_WIDTH, 32, AXI data width; 32 or 64 only.
NUM_REGS, 8, number of DATA_WIDTH-bit registers; 1..256.
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only, sourced from hw_status.
PRIV_ONLY, 0, 1 = reject accesses with prot[0]=0 (unprivileged).
RESET_VAL, 0, DATA_WIDTH-bit reset value of every RW register.

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
awaddr  in  ADDR_WIDTH  write address
awvalid  in  1  AW valid
awready  out  1  AW ready
awprot  in  3  AW protection
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte strobes
wvalid  in  1  W valid
wready  out  1  W ready
bresp  out  2  write response
bvalid  out  1  B valid
bready  in  1  B ready
araddr  in  ADDR_WIDTH  read address
arvalid  in  1  AR valid
arready  out  1  AR ready
arprot  in  3  AR protection
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rvalid  out  1  R valid
rready  in  1  R ready
reg_q  out  NUM_REGS*DATA_WIDTH  flattened RW register contents; register i at [i*DATA_WIDTH +: DATA_WIDTH]
wr_pulse  out  NUM_REGS  one-cycle strobe per successfully written register
hw_status  in  NUM_REGS*DATA_WIDTH  read values for RO registers; slices for RW registers are ignored

Behaviour:
- Clock and reset: one clock, aclk. aresetn is synchronous and active-low.
- Reset (aresetn=0 at a rising edge):
  - bvalid, rvalid, wr_pulse, rdata and bresp/rresp go to 0.
  - Both holding buffers are emptied.
  - RW registers load RESET_VAL; reg_q slices of RO registers read 0.
  - Ready signals follow the rules below, so awready=wready=arready=1 in the first cycle after reset.
  - Reset mid-transaction drops every held or pending transaction; no B or R response is issued for it.
- Decode:
  - Byte lane count = DATA_WIDTH/8. LSB = log2(byte lane count). Index = awaddr/araddr >> LSB.
  - Address bits below LSB are ignored.
  - Index >= NUM_REGS -> DECERR-class error, reported as SLVERR (2'b10).
- Write path:
  - AW holding buffer: awready = !aw_held && !bvalid. Handshake captures awaddr and awprot.
  - W holding buffer: wready = !w_held && !bvalid. Handshake captures wdata and wstrb.
  - AW and W may arrive in either order or in the same cycle.
  - Commit: on the first rising edge where both buffers are held and bvalid=0:
    - If the access is OK, bytes with wstrb=1 are updated in register[idx] and wr_pulse[idx]=1 for exactly that cycle. This holds even when wstrb=0.
    - Both buffers clear, bvalid=1, and bresp = OKAY (00) or SLVERR (10).
  - Error cases (no register update, no wr_pulse):
    - idx out of range;
    - RO_MASK[idx]=1;
    - PRIV_ONLY=1 and awprot[0]=0.
  - Latency: the commit edge is the edge after the later of the AW/W handshakes.
  - bvalid and bresp hold until bready=1 at a rising edge; bvalid then drops. New AW/W handshakes are possible in that same cycle.
- Read path:
  - arready = !rvalid.
  - At the AR handshake edge: rvalid=1. rdata = register[idx], or hw_status slice if RO.
  - rresp = OKAY. On out-of-range index or privilege failure: SLVERR with rdata=0.
  - rvalid, rdata and rresp hold stable until rready=1 at an edge.
- Simultaneous read and write commit to the same register on one edge: the read returns the pre-write value.
- Read and write paths are fully independent; neither stalls the other.
- All outputs are registered; there are no combinational input-to-output paths except through the ready equations above.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x04 with wstrb=4'hF, AW and W in the same cycle -> bvalid two edges later, bresp=00, wr_pulse[1] for 1 cycle, reg_q[63:32]=0xDEADBEEF. Read of 0x04 -> rvalid one edge after AR, rdata=0xDEADBEEF, rresp=00.
- W three cycles before AW, then partial write wstrb=4'b0010 data 0x0000AA00 to reg 1 -> reg 1 = 0xDEADAAEF. Hold bready=0 for 4 cycles -> bvalid, bresp, awready=0 and wready=0 stable throughout.
- Write to addr 0x20 with NUM_REGS=8 -> bresp=10, no wr_pulse, reg_q unchanged. Read of 0x20 -> rresp=10, rdata=0.
- RO_MASK=8'h04 with hw_status reg2 = 0x12345678: read 0x08 -> 0x12345678/OKAY. Write 0x08 -> SLVERR, no wr_pulse.
- PRIV_ONLY=1: write with awprot=3'b000 -> SLVERR, no update. Same write with awprot=3'b001 -> OKAY.
- With reg3=5, an AR to reg 3 and a commit writing 9 to reg 3 land on the same edge -> rdata=5, then reg3=9. Assert aresetn=0 while bvalid and rvalid are pending -> both 0 after the edge, reg_q=RESET_VAL, readies=1.
